float_mul_pipe: RTL and testbench

- Parametrised, pipelined multiplier for the team's packed {sign, exponent, mantissa} float format, with a valid/ready stream handshake on both sides.
- Generalises the fixed 24-bit multiply path; the default format is 1/7/16 with bias 63.
- Adds a backpressure stall, a defined fixed latency, sign handling, and saturating overflow/underflow flags aligned to each result.
- Sits between operand source and result sink in top_level.

---
 rtl/float_mul_pipe.sv | 140 ++++++++++++++
 tb/tb_float_mul_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_mul_pipe.sv
// Three-stage pipelined multiplier for packed {sign, exponent, mantissa} floats with valid/ready handshake.
// Define FLOAT_MUL_ROUND_NEAREST_EN for round-to-nearest-even in S3; otherwise the fraction is truncated.
module float_mul_pipe #(
  parameter int unsigned EXP_W = 7,
  parameter int unsigned MAN_W = 16,
  parameter int unsigned BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   float_a,
  input  logic [EXP_W+MAN_W:0]   float_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   float_out,
  output logic                   float_out_underflow,
  output logic                   float_out_overflow
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * (MAN_W + 1);
  localparam int unsigned EW = EXP_W + 2;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
  localparam int unsigned KW = PW;
`else
  // Truncation only needs the product bits that can reach the fraction.
  localparam int unsigned KW = MAN_W + 2;
`endif
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);

  logic v1, v2, v3, stall;

  assign stall     = v3 && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3;

  // S1: sign, zero detect, biased exponent sum, significand product
  logic                 s1_sign, s1_zero;
  logic signed [EW-1:0] s1_exp;
  logic [KW-1:0]        s1_prod;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign <= float_a[W-1] ^ float_b[W-1];
      s1_zero <= (float_a[W-2 -: EXP_W] == '0) || (float_b[W-2 -: EXP_W] == '0);
      s1_exp  <= $signed(EW'(float_a[W-2 -: EXP_W])) + $signed(EW'(float_b[W-2 -: EXP_W])) - BIAS_E;
      s1_prod <= KW'((PW'({1'b1, float_a[MAN_W-1:0]}) * PW'({1'b1, float_b[MAN_W-1:0]})) >> (PW - KW));
    end
  end

  // S2: normalise so the hidden one sits just above the fraction
  logic                 hi;
  logic [MAN_W-1:0]     frac_c;
  logic signed [EW-1:0] exp_c;
  logic                 s2_sign, s2_zero;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_frac;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
  logic guard_c, sticky_c, s2_guard, s2_sticky;
`endif

  always_comb begin
    hi     = s1_prod[KW-1];
    frac_c = hi ? s1_prod[KW-2 -: MAN_W] : s1_prod[KW-3 -: MAN_W];
    exp_c  = s1_exp + $signed(EW'(hi));
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    guard_c  = hi ? s1_prod[KW-2-MAN_W] : s1_prod[KW-3-MAN_W];
    sticky_c = hi ? (|s1_prod[KW-3-MAN_W:0]) : (|s1_prod[KW-4-MAN_W:0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_exp    <= exp_c;
      s2_frac   <= frac_c;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
      s2_guard  <= guard_c;
      s2_sticky <= sticky_c;
`endif
    end
  end

  // S3: round, then classify against the representable exponent range
  logic [MAN_W-1:0]     frac_r;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         res_c;
  logic                 ovf_c, unf_c;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
  logic                 round_up, carry;
`endif

  always_comb begin
    frac_r = s2_frac;
    exp_r  = s2_exp;
    res_c  = '0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    round_up        = s2_guard & (s2_sticky | s2_frac[0]);
    {carry, frac_r} = {1'b0, s2_frac} + (MAN_W+1)'(round_up);
    exp_r           = s2_exp + $signed(EW'(carry));
`endif
    if (s2_zero) begin
      res_c = {s2_sign, (W-1)'(0)};
    end else if (exp_r > EXP_MAX) begin
      res_c = {s2_sign, {(W-1){1'b1}}};
      ovf_c = 1'b1;
    end else if (exp_r < EXP_ONE) begin
      res_c = {s2_sign, (W-1)'(0)};
      unf_c = 1'b1;
    end else begin
      res_c = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    end
  end

  // Valid bits and result registers; bubbles leave the outputs at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      v1                  <= 1'b0;
      v2                  <= 1'b0;
      v3                  <= 1'b0;
      float_out           <= '0;
      float_out_overflow  <= 1'b0;
      float_out_underflow <= 1'b0;
    end else if (!stall) begin
      v1                  <= in_valid;
      v2                  <= v1;
      v3                  <= v2;
      float_out           <= v2 ? res_c : '0;
      float_out_overflow  <= v2 & ovf_c;
      float_out_underflow <= v2 & unf_c;
    end
  end

endmodule

// File: tb/tb_float_mul_pipe.sv
// Scoreboard bench for float_mul_pipe: directed spec vectors plus randomized traffic checked
// against an integer reference model; honours FLOAT_MUL_ROUND_NEAREST_EN for the rounding mode.
module tb_float_mul_pipe;

  localparam int unsigned EXP_W = 7;
  localparam int unsigned MAN_W = 16;
  localparam int unsigned BIAS  = 63;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] float_a, float_b, float_out;
  logic         float_out_underflow, float_out_overflow;

  float_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float_a(float_a), .float_b(float_b), .out_valid(out_valid), .out_ready(out_ready),
    .float_out(float_out), .float_out_underflow(float_out_underflow),
    .float_out_overflow(float_out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    int           cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0, cyc = 0, popped = 0;
  bit   saw_ready_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Exact integer product, then renormalise and round from the bits that fall off.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    int ea, eb, e, msb, drop;
    longint unsigned p, q, one;
    logic s;
    one = 1;
    s = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    r.res = {s, (W-1)'(0)};
    r.ovf = 1'b0; r.unf = 1'b0; r.cyc = 0; r.chk_lat = 1'b0;
    if (ea == 0 || eb == 0) return r;
    p = ((one << MAN_W) + 64'(a[MAN_W-1:0])) * ((one << MAN_W) + 64'(b[MAN_W-1:0]));
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    drop = msb - int'(MAN_W);
    q = p >> drop;
    e = ea + eb - int'(BIAS) + (msb - 2 * int'(MAN_W));
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    begin
      longint unsigned rem, half;
      rem  = p - (q << drop);
      half = one << (drop - 1);
      if (rem > half || (rem == half && q[0])) begin
        q++;
        if (q == (one << (MAN_W + 1))) begin
          q = q >> 1;
          e++;
        end
      end
    end
`endif
    if (e > (1 << EXP_W) - 1) begin
      r.res = {s, {(W-1){1'b1}}};
      r.ovf = 1'b1;
    end else if (e < 1) begin
      r.unf = 1'b1;
    end else begin
      r.res = {s, EXP_W'(e), MAN_W'(q - (one << MAN_W))};
    end
    return r;
  endfunction

  // Present one operand pair, wait (bounded) for acceptance, record its expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit ok;
    ok = 0;
    float_a = a; float_b = b; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res,
                     input logic ovf, input logic unf);
    exp_t e;
    e.res = res; e.ovf = ovf; e.unf = unf; e.cyc = 0; e.chk_lat = 1'b1;
    send(a, b, e);
  endtask

  task automatic rnd_op(input bit lat);
    logic [W-1:0] a, b;
    exp_t e;
    a = W'($urandom);
    b = W'($urandom);
    if ($urandom_range(0, 15) == 0) a[W-2:MAN_W] = '0;
    if ($urandom_range(0, 15) == 0) b[W-2:MAN_W] = '0;
    e = model(a, b);
    e.chk_lat = lat;
    send(a, b, e);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every presented result is compared with the queue head; popped on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (!in_ready) saw_ready_low = 1;
      check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got %h expected no result", float_out);
        end else begin
          mon_e = sb[0];
          check("float_out", int'(float_out), int'(mon_e.res));
          check("overflow", int'(float_out_overflow), int'(mon_e.ovf));
          check("underflow", int'(float_out_underflow), int'(mon_e.unf));
          if (out_ready) begin
            if (mon_e.chk_lat) check("latency", cyc - mon_e.cyc, 3);
            void'(sb.pop_front());
            popped++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    bit done;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; float_a = '0; float_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_float_out", int'(float_out), 0);
    check("rst_flags", int'({float_out_overflow, float_out_underflow}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    dir(24'h469040, 24'h3D8000, 24'h452C30, 1'b0, 1'b0);
    idle(5);

    // Back-to-back: each result must still appear exactly 3 cycles after its acceptance
    dir(24'hC00000, 24'h408000, 24'hC18000, 1'b0, 1'b0);
    dir(24'h000000, 24'h3E0000, 24'h000000, 1'b0, 1'b0);
    dir(24'h7F0000, 24'h400000, 24'h7FFFFF, 1'b1, 1'b0);
    dir(24'h3754C9, 24'h010000, 24'h000000, 1'b0, 1'b1);
`ifdef FLOAT_MUL_ROUND_NEAREST_EN
    dir(24'h3F0001, 24'h3F8000, 24'h3F8002, 1'b0, 1'b0);
`else
    dir(24'h3F0001, 24'h3F8000, 24'h3F8001, 1'b0, 1'b0);
`endif
    idle(6);

    // Backpressure: sink refuses for 5 cycles while 6 pairs stream in
    p0 = popped;
    saw_ready_low = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) rnd_op(1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(10);
    check("bp_count", popped - p0, 6);
    check("bp_in_ready_dropped", int'(saw_ready_low), 1);

    // Reset with two operations in flight: they must never surface
    rnd_op(1'b0);
    rnd_op(1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", int'(out_valid), 0);
      check("post_rst_out", int'({float_out, float_out_overflow, float_out_underflow}), 0);
      @(posedge clk); #1;
    end
    dir(24'hC00000, 24'h408000, 24'hC18000, 1'b0, 1'b0);
    idle(6);

    // Random traffic with random input gaps and random sink backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle(int'($urandom_range(0, 2)));
          rnd_op(1'b0);
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(20);
    check("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
